// File: rtl/nr4sdm_recoder_seq.sv
// nr4sdm_recoder_seq
//   Sequential NR4SD- recoder for a WIDTH-bit two's-complement operand.
//   Produces one radix-4 digit per RUN cycle: K-1 NR4SD- digits (values
//   -2..1) for the lower pairs, plus a Modified Booth digit for the top pair.
//   The digit sum over j of digit_j * 4^j equals the signed operand.
//
//   Build option: define NR4SDM_TWO_DIGIT_EN to recode two digits per RUN
//   cycle. Carry is chained combinationally between the two digits.
//   Outputs and handshake are the same in both builds; only latency changes.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid, in_ready    operand handshake (accepted in IDLE only)
//   in_a [WIDTH-1:0]      operand, two's complement
//   out_valid, out_ready  result handshake (held in DONE until out_ready)
//   out_nm, out_np [K-2:0] NR4SD- digit bits, bit j = digit j
//   out_sign/one/two      MB encoding of the top digit K-1
//   busy                  high while recoding (RUN)
//
// States
//   IDLE | waiting for an operand, in_ready = 1
//   RUN  | recoding digits at the current index
//   DONE | result valid and held until out_ready
module nr4sdm_recoder_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-2:0] out_nm,
  output logic [WIDTH/2-2:0] out_np,
  output logic               out_sign,
  output logic               out_one,
  output logic               out_two,
  output logic               busy
);

  localparam int K  = WIDTH / 2;
  localparam int IW = $clog2(K + 1);
`ifdef NR4SDM_TWO_DIGIT_EN
  localparam int DPC = 2;
`else
  localparam int DPC = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Operand is shifted right two bits per digit, so bits [1:0] always hold
  // the pair for the digit at idx.
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic             carry, carry_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [K-2:0]     nm_reg, nm_nxt, np_reg, np_nxt;
  logic             sign_reg, sign_nxt, one_reg, one_nxt, two_reg, two_nxt;

  logic [WIDTH-1:0] a_t;
  logic             c_t, c1, fin;
  logic [IW-1:0]    i_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      nm_reg   <= '0;
      np_reg   <= '0;
      sign_reg <= 1'b0;
      one_reg  <= 1'b0;
      two_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      a_reg    <= a_nxt;
      carry    <= carry_nxt;
      idx      <= idx_nxt;
      nm_reg   <= nm_nxt;
      np_reg   <= np_nxt;
      sign_reg <= sign_nxt;
      one_reg  <= one_nxt;
      two_reg  <= two_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    carry_nxt = carry;
    idx_nxt   = idx;
    nm_nxt    = nm_reg;
    np_nxt    = np_reg;
    sign_nxt  = sign_reg;
    one_nxt   = one_reg;
    two_nxt   = two_reg;
    a_t       = a_reg;
    c_t       = carry;
    i_t       = idx;
    c1        = 1'b0;
    fin       = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt     = in_a;
          carry_nxt = 1'b0;
          idx_nxt   = '0;
          nm_nxt    = '0;
          np_nxt    = '0;
          sign_nxt  = 1'b0;
          one_nxt   = 1'b0;
          two_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Up to DPC digits per cycle; once the MB digit is encoded the
        // remaining slot (odd K in the two-digit build) does nothing.
        for (int s = 0; s < DPC; s++) begin
          if (!fin) begin
            if (i_t == IW'(K - 1)) begin
              sign_nxt = a_t[1];
              one_nxt  = a_t[0] ^ c_t;
              two_nxt  = (a_t[1] & ~a_t[0] & ~c_t) | (~a_t[1] & a_t[0] & c_t);
              fin      = 1'b1;
            end else begin
              c1 = a_t[0] & c_t;
              for (int i = 0; i < K - 1; i++) begin
                if (i_t == IW'(i)) begin
                  np_nxt[i] = a_t[0] ^ c_t;
                  nm_nxt[i] = a_t[1] ^ c1;
                end
              end
              c_t = a_t[1] | c1;
              a_t = a_t >> 2;
              i_t = i_t + IW'(1);
            end
          end
        end
        a_nxt     = a_t;
        carry_nxt = c_t;
        idx_nxt   = i_t;
        if (fin) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_nm    = nm_reg;
  assign out_np    = np_reg;
  assign out_sign  = sign_reg;
  assign out_one   = one_reg;
  assign out_two   = two_reg;

endmodule

// File: tb/tb_nr4sdm_recoder_seq.sv
module tb_nr4sdm_recoder_seq;

`ifdef NR4SDM_TWO_DIGIT_EN
  localparam int LAT8  = 3;
  localparam int LAT16 = 5;
  localparam int PER8  = 4;
`else
  localparam int LAT8  = 5;
  localparam int LAT16 = 9;
  localparam int PER8  = 6;
`endif

  // {np[2:0], nm[2:0], sign, one, two}
  localparam logic [7:0] DIR_A [6] = '{8'h55, 8'hFF, 8'h7F, 8'h80, 8'h02, 8'hC0};
  localparam logic [8:0] DIR_E [6] = '{9'b111_000_010, 9'b001_001_100, 9'b001_001_001,
                                       9'b000_000_101, 9'b010_001_000, 9'b000_000_110};
  localparam logic [15:0] CORN [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0] in_a8;
  logic [2:0] nm8, np8;
  logic       sign8, one8, two8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] in_a16;
  logic [6:0]  nm16, np16;
  logic        sign16, one16, two16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nr4sdm_recoder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_nm(nm8), .out_np(np8),
    .out_sign(sign8), .out_one(one8), .out_two(two8),
    .busy(busy8)
  );

  nr4sdm_recoder_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_nm(nm16), .out_np(np16),
    .out_sign(sign16), .out_one(one16), .out_two(two16),
    .busy(busy16)
  );

  task automatic run_op8(input logic [7:0] a, output int lat);
    @(negedge clk);
    in_a8 = a;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8;
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic run_op16(input logic [15:0] a, output int lat);
    @(negedge clk);
    in_a16 = a;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release16;
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({out_valid8, busy8, in_ready8, np8, nm8, sign8, one8, two8} !== 12'b001_000000_000) begin
      n_fail++;
      $display("FAIL reset8: got v=%b b=%b r=%b np=%b nm=%b s/o/t=%b%b%b, want 0 0 1 0 0 000",
               out_valid8, busy8, in_ready8, np8, nm8, sign8, one8, two8);
    end
    n_checks++;
    if ({out_valid16, busy16, in_ready16, np16, nm16, sign16, one16, two16} !== 20'h20000) begin
      n_fail++;
      $display("FAIL reset16: got v=%b b=%b r=%b np=%b nm=%b, want 0 0 1 0 0",
               out_valid16, busy16, in_ready16, np16, nm16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got r=%b v=%b b=%b, want 1 0 0", in_ready8, out_valid8, busy8);
    end
  endtask

  task automatic test_directed;
    int lat;
    for (int n = 0; n < 6; n++) begin
      run_op8(DIR_A[n], lat);
      n_checks++;
      if (lat !== LAT8) begin
        n_fail++;
        $display("FAIL dir_latency a=%h: got %0d edges, want %0d", DIR_A[n], lat, LAT8);
      end
      n_checks++;
      if ({np8, nm8, sign8, one8, two8} !== DIR_E[n]) begin
        n_fail++;
        $display("FAIL dir_digits a=%h: got %b, want %b", DIR_A[n],
                 {np8, nm8, sign8, one8, two8}, DIR_E[n]);
      end
      n_checks++;
      if (in_ready8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_done_flags a=%h: got r=%b b=%b, want 0 0", DIR_A[n], in_ready8, busy8);
      end
      release8();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    run_op8(8'h55, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid8 = c[0];
      in_a8 = 8'hA3;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 ||
          {np8, nm8, sign8, one8, two8} !== 9'b111_000_010) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v=%b r=%b bits=%b, want 1 0 111000010",
                 c, out_valid8, in_ready8, {np8, nm8, sign8, one8, two8});
      end
    end
    in_valid8 = 1'b0;
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    n_checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b r=%b, want 0 1", out_valid8, in_ready8);
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    @(negedge clk);
    in_valid8 = 1'b1;
    in_a8 = 8'h7F;
    out_ready8 = 1'b1;
    for (int c = 0; c < 3 * PER8 + 2; c++) begin
      if (in_ready8) acc.push_back(c);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    n_checks++;
    if (acc.size() < 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts, want >= 3", acc.size());
    end else if (acc[1] - acc[0] != PER8 || acc[2] - acc[1] != PER8) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d and %0d cycles, want %0d",
               acc[1] - acc[0], acc[2] - acc[1], PER8);
    end
    repeat (PER8 + 2) @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int lat;
    @(negedge clk);
    in_a8 = 8'hFF;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b, want 1", busy8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid8, busy8, in_ready8, np8, nm8, sign8, one8, two8} !== 12'b001_000000_000) begin
      n_fail++;
      $display("FAIL midrun_reset: got v=%b b=%b r=%b np=%b nm=%b s/o/t=%b%b%b, want 0 0 1 0 0 000",
               out_valid8, busy8, in_ready8, np8, nm8, sign8, one8, two8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'h7F, lat);
    n_checks++;
    if (lat !== LAT8 || {np8, nm8, sign8, one8, two8} !== 9'b001_001_001) begin
      n_fail++;
      $display("FAIL midrun_next: got lat=%0d bits=%b, want lat=%0d bits=001001001",
               lat, {np8, nm8, sign8, one8, two8}, LAT8);
    end
    release8();
  endtask

  task automatic test_random16;
    int lat, sum, top, exp_v;
    logic [15:0] a;
    for (int n = 0; n < 1004; n++) begin
      a = (n < 4) ? CORN[n] : 16'($urandom);
      run_op16(a, lat);
      sum = 0;
      for (int j = 0; j < 7; j++)
        sum += (int'(np16[j]) - 2 * int'(nm16[j])) * (1 << (2 * j));
      top = int'(one16) + 2 * int'(two16);
      if (sign16) top = -top;
      sum += top * (1 << 14);
      exp_v = int'($signed(a));
      n_checks++;
      if (sum !== exp_v || (one16 & two16) || sign16 !== a[15]) begin
        n_fail++;
        $display("FAIL rand_value a=%h: got sum=%0d s/o/t=%b%b%b, want %0d sign=%b",
                 a, sum, sign16, one16, two16, exp_v, a[15]);
      end
      n_checks++;
      if (lat !== LAT16) begin
        n_fail++;
        $display("FAIL rand_latency a=%h: got %0d edges, want %0d", a, lat, LAT16);
      end
      release16();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; in_a16 = '0; out_ready16 = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_random16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
